// File: rtl/imem_loadable_pkg.sv
// Shared definitions for the loadable instruction memory: FSM encoding and
// default geometry used by the interface, the RAM and the top.
package imem_loadable_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DEPTH_LOG2 = 6;

    localparam logic [DEF_DATA_W-1:0] DEF_NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } imem_state_e;

endpackage

// File: rtl/imem_loadable_if.sv
// Loader stream plus fetch port of the instruction memory. The master side is
// the boot controller / core, the slave side is the memory itself.
interface imem_loadable_if #(
    parameter int DATA_W = imem_loadable_pkg::DEF_DATA_W,
    parameter int ADDR_W = imem_loadable_pkg::DEF_ADDR_W
) ();

    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              load_done;

    logic              fetch_en;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instruction;
    logic              instr_valid;
    logic              misaligned;
    logic              out_of_range;
    logic              cpu_stall;

    modport master (
        output load_start, load_valid, load_data, load_last, fetch_en, pc,
        input  load_ready, load_done, instruction, instr_valid,
               misaligned, out_of_range, cpu_stall
    );

    modport slave (
        input  load_start, load_valid, load_data, load_last, fetch_en, pc,
        output load_ready, load_done, instruction, instr_valid,
               misaligned, out_of_range, cpu_stall
    );

endinterface

// File: rtl/imem_loadable_array.sv
// Single-port synchronous word RAM; a write takes the port, otherwise a read
// enable updates the registered read data, which holds between reads.
module imem_array #(
    parameter int DATA_W     = imem_loadable_pkg::DEF_DATA_W,
    parameter int DEPTH_LOG2 = imem_loadable_pkg::DEF_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/imem_loadable.sv
// Instruction memory loaded over a valid/ready stream after reset, then serving
// one-cycle registered fetches; invalid fetches return NOP_WORD with a flag.
module imem_loadable
    import imem_loadable_pkg::*;
#(
    parameter int                DATA_W     = DEF_DATA_W,
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter logic [DATA_W-1:0] NOP_WORD   = DATA_W'(DEF_NOP_WORD)
) (
    input  logic           clk,
    input  logic           rst_n,
    imem_loadable_if.slave bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    imem_state_e state, state_nxt;

    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH-1:0]      written;
    logic                  load_done_r;

    logic                  load_ready;
    logic                  cpu_stall;
    logic                  fetch_fire;
    logic                  load_fire;
    logic                  last_beat;
    logic                  clear_prog;

    logic                  pc_misaligned;
    logic                  pc_out_of_range;
    logic [DEPTH_LOG2-1:0] fetch_idx;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [DATA_W-1:0]     ram_rdata;

    logic                  use_nop_p1;
    logic                  vld_p1;
    logic                  misaligned_p1;
    logic                  out_of_range_p1;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; load_start during LOAD is deliberately ignored
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.load_start) state_nxt = ST_LOAD;
            ST_LOAD: if (last_beat)      state_nxt = ST_RUN;
            ST_RUN:  if (bus.load_start) state_nxt = ST_LOAD;
            default:                     state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        load_ready = 1'b0;
        cpu_stall  = 1'b1;
        fetch_fire = 1'b0;
        case (state)
            ST_LOAD: load_ready = 1'b1;
            ST_RUN: begin
                cpu_stall  = 1'b0;
                fetch_fire = bus.fetch_en;
            end
            default: ;
        endcase
    end

    assign load_fire  = load_ready & bus.load_valid;
    assign last_beat  = load_fire & (bus.load_last | (&wptr));
    assign clear_prog = bus.load_start & (state != ST_LOAD);

    assign pc_misaligned   = |bus.pc[1:0];
    assign pc_out_of_range = |bus.pc[ADDR_W-1:DEPTH_LOG2+2];
    assign fetch_idx       = bus.pc[DEPTH_LOG2+1:2];

    // Writes and fetches are gated by state, so the single port never conflicts
    assign ram_addr = (state == ST_LOAD) ? wptr : fetch_idx;

    imem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (load_fire),
        .re    (fetch_fire),
        .addr  (ram_addr),
        .wdata (bus.load_data),
        .rdata (ram_rdata)
    );

    // Write pointer and written-word bitmap; a new program invalidates every word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr        <= '0;
            written     <= '0;
            load_done_r <= 1'b0;
        end else begin
            load_done_r <= last_beat;
            if (clear_prog) begin
                wptr    <= '0;
                written <= '0;
            end else if (load_fire) begin
                wptr          <= wptr + 1'b1;
                written[wptr] <= 1'b1;
            end
        end
    end

    // Stage p1: fetch result qualifiers, aligned with the RAM read register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            use_nop_p1      <= 1'b1;
            vld_p1          <= 1'b0;
            misaligned_p1   <= 1'b0;
            out_of_range_p1 <= 1'b0;
        end else if (state_nxt != ST_RUN) begin
            use_nop_p1      <= 1'b1;
            vld_p1          <= 1'b0;
            misaligned_p1   <= 1'b0;
            out_of_range_p1 <= 1'b0;
        end else begin
            vld_p1 <= fetch_fire;
            if (fetch_fire) begin
                misaligned_p1   <= pc_misaligned;
                out_of_range_p1 <= ~pc_misaligned & pc_out_of_range;
                use_nop_p1      <= pc_misaligned | pc_out_of_range | ~written[fetch_idx];
            end
        end
    end

    assign bus.instruction  = use_nop_p1 ? NOP_WORD : ram_rdata;
    assign bus.instr_valid  = vld_p1;
    assign bus.misaligned   = misaligned_p1;
    assign bus.out_of_range = out_of_range_p1;
    assign bus.load_ready   = load_ready;
    assign bus.load_done    = load_done_r;
    assign bus.cpu_stall    = cpu_stall;

endmodule

// File: tb/tb_imem_loadable.sv
// Scoreboard bench for imem_loadable: a word/bitmap model predicts each fetch,
// predictions are queued at drive time and popped when the result appears.
module tb_imem_loadable;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic        valid;
        logic        mis;
        logic        oor;
    } fetch_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    imem_loadable_if bus ();

    imem_loadable dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    fetch_exp_t  sb_q[$];
    fetch_exp_t  last_e;
    logic [31:0] prog_q[$];
    logic [31:0] mem_m [64];
    bit          written_m [64];
    int          wptr_m;
    bit          run_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic fetch_exp_t model_fetch(input logic [31:0] a);
        fetch_exp_t e;
        e.valid = run_m;
        e.mis   = 1'b0;
        e.oor   = 1'b0;
        e.instr = NOP;
        if (run_m) begin
            if (a[1:0] != 2'b00)      e.mis = 1'b1;
            else if (a >= 32'h100)    e.oor = 1'b1;
            else if (written_m[a[7:2]]) e.instr = mem_m[a[7:2]];
        end
        return e;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 64; i++) written_m[i] = 1'b0;
        wptr_m = 0;
        run_m  = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input string tag);
        fetch_exp_t e;
        @(negedge clk);
        bus.fetch_en = 1'b1;
        bus.pc       = a;
        sb_q.push_back(model_fetch(a));
        @(posedge clk);
        #1;
        bus.fetch_en = 1'b0;
        e = sb_q.pop_front();
        check({tag, "_instr"}, bus.instruction, e.instr);
        check({tag, "_vld"}, 32'(bus.instr_valid), 32'(e.valid));
        check({tag, "_mis"}, 32'(bus.misaligned), 32'(e.mis));
        check({tag, "_oor"}, 32'(bus.out_of_range), 32'(e.oor));
        last_e = e;
    endtask

    task automatic hold_check(input string tag);
        @(negedge clk);
        @(posedge clk);
        #1;
        check({tag, "_vld"}, 32'(bus.instr_valid), 32'd0);
        check({tag, "_instr"}, bus.instruction, last_e.instr);
        check({tag, "_mis"}, 32'(bus.misaligned), 32'(last_e.mis));
        check({tag, "_oor"}, 32'(bus.out_of_range), 32'(last_e.oor));
    endtask

    // Loads prog_q; with_beat presents a (non-accepted) beat together with load_start
    task automatic load_prog(input bit mark_last, input bit with_beat);
        @(negedge clk);
        bus.load_start = 1'b1;
        bus.load_valid = with_beat;
        bus.load_last  = with_beat;
        bus.load_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.load_start = 1'b0;
        clear_model();
        check("load_stall", 32'(bus.cpu_stall), 32'd1);
        check("load_vld0", 32'(bus.instr_valid), 32'd0);
        check("load_nop", bus.instruction, NOP);
        for (int i = 0; i < prog_q.size(); i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = prog_q[i];
            bus.load_last  = mark_last && (i == prog_q.size() - 1);
            check("load_ready", 32'(bus.load_ready), 32'd1);
            @(negedge clk);
            mem_m[wptr_m]     = prog_q[i];
            written_m[wptr_m] = 1'b1;
            wptr_m++;
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        run_m = 1'b1;
        check("load_done", 32'(bus.load_done), 32'd1);
        check("ready_after", 32'(bus.load_ready), 32'd0);
        check("stall_after", 32'(bus.cpu_stall), 32'd0);
        @(negedge clk);
        check("done_pulse", 32'(bus.load_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_last  = 1'b0;
        bus.fetch_en   = 1'b0;
        bus.pc         = '0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check("rst_instr", bus.instruction, NOP);
        check("rst_vld", 32'(bus.instr_valid), 32'd0);
        check("rst_mis", 32'(bus.misaligned), 32'd0);
        check("rst_oor", 32'(bus.out_of_range), 32'd0);
        check("rst_ready", 32'(bus.load_ready), 32'd0);
        check("rst_done", 32'(bus.load_done), 32'd0);
        check("rst_stall", 32'(bus.cpu_stall), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        fetch(32'h0, "idle");

        // 16-word program, then a plain fetch and the invalid-fetch cases
        prog_q = {32'h2002_0005, 32'h2007_0003, 32'h2003_000c};
        for (int i = 3; i < 16; i++) begin
            w = 32'h2000_0000 | 32'(i << 16) | 32'(i);
            prog_q.push_back(w);
        end
        load_prog(1'b1, 1'b0);
        fetch(32'h8, "t1_w2");
        fetch(32'h0, "t1_w0");
        fetch(32'h3C, "t1_w15");
        fetch(32'h6, "t2_mis");
        hold_check("t2_hold");
        fetch(32'h100, "t2_oor");
        fetch(32'h102, "t2_both");
        fetch(32'hFFFF_FFFC, "t2_high");
        fetch(32'h40, "t3_unw");

        // full memory without load_last
        prog_q.delete();
        for (int i = 0; i < 64; i++) begin
            w = 32'hC0DE_0000 | 32'(i);
            prog_q.push_back(w);
        end
        load_prog(1'b0, 1'b0);
        fetch(32'hFC, "t4_last");
        fetch(32'h40, "t4_w16");

        // reset in the middle of a load
        @(negedge clk);
        bus.load_start = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 32'h5500_0000 | 32'(i);
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", 32'(bus.load_ready), 32'd0);
        check("arst_stall", 32'(bus.cpu_stall), 32'd1);
        check("arst_done", 32'(bus.load_done), 32'd0);
        check("arst_vld", 32'(bus.instr_valid), 32'd0);
        check("arst_instr", bus.instruction, NOP);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(bus.load_ready), 32'd0);
        bus.load_valid = 1'b0;
        prog_q = {32'h1234_5678};
        load_prog(1'b1, 1'b0);
        fetch(32'h4, "t5_w1");
        fetch(32'h0, "t5_w0");

        // reload from RUN with a beat coincident with load_start
        prog_q = {32'hAAAA_0000, 32'hBBBB_0001};
        load_prog(1'b1, 1'b1);
        fetch(32'h4, "t6_w1");
        fetch(32'h8, "t6_w2");
        fetch(32'h0, "t6_w0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
